// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl - instruction-fetch sequencer.
//
// Owns the PC and issues one fetch at a time over a req/gnt/rvalid
// handshake. The fetched word is held in an instruction register until
// decode takes it (i_ins_rdy). A redirect replaces the PC and, if a fetch
// is already in flight, marks its response to be thrown away.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | one cycle after reset release, nothing issued yet
// S_REQ  | request driven at pc, waiting for i_imem_gnt
// S_WAIT | fetch accepted, waiting for i_imem_rvalid
// S_HOLD | o_ins is live, waiting for decode to consume it
//
// Ports:
//   i_clk, i_reset        clock, async active-low reset
//   o_imem_req/addr       fetch request and its word-aligned address
//   i_imem_gnt            memory accepts the request
//   i_imem_rvalid/rdata   read response
//   o_ins/o_ins_pc        instruction register and its address
//   o_ins_vld, i_ins_rdy  handshake to decode
//   i_redirect(_pc)       PC replacement from branch/jump resolution

module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_ins,
    output logic [31:0] o_ins_pc,
    output logic        o_ins_vld,
    input  logic        i_ins_rdy,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] ins_pc_q, ins_pc_d;
    logic        ins_vld_q, ins_vld_d;
    logic        drop_q, drop_d;
    logic        imem_req_q, imem_req_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ins_d     = ins_q;
        ins_pc_d  = ins_pc_q;
        ins_vld_d = ins_vld_q;
        drop_d    = drop_q;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (i_imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        ins_d     = i_imem_rdata;
                        ins_pc_d  = pc_q;
                        ins_vld_d = 1'b1;
                        pc_d      = pc_q + 32'd4;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (i_ins_rdy) begin
                    ins_vld_d = 1'b0;
                    state_d   = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect overrides everything above. A fetch that has been granted
        // but not yet answered must have its response discarded (drop).
        if (i_redirect) begin
            pc_d      = {i_redirect_pc[31:2], 2'b00};
            ins_vld_d = 1'b0;
            ins_d     = ins_q;
            ins_pc_d  = ins_pc_q;
            case (state_q)
                S_REQ: begin
                    if (i_imem_gnt) begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end

        imem_req_d = (state_d == S_REQ);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ins_q      <= NOP;
            ins_pc_q   <= RESET_PC;
            ins_vld_q  <= 1'b0;
            drop_q     <= 1'b0;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ins_q      <= ins_d;
            ins_pc_q   <= ins_pc_d;
            ins_vld_q  <= ins_vld_d;
            drop_q     <= drop_d;
            imem_req_q <= imem_req_d;
        end
    end

    assign o_imem_req  = imem_req_q;
    assign o_imem_addr = pc_q;
    assign o_ins       = ins_q;
    assign o_ins_pc    = ins_pc_q;
    assign o_ins_vld   = ins_vld_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
module tb_ifetch_ctrl;

    logic        i_clk;
    logic        i_reset;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_ins;
    logic [31:0] o_ins_pc;
    logic        o_ins_vld;
    logic        i_ins_rdy;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;

    int unsigned n_cmp;
    int unsigned n_bad;

    ifetch_ctrl dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_ins         (o_ins),
        .o_ins_pc      (o_ins_pc),
        .o_ins_vld     (o_ins_vld),
        .i_ins_rdy     (i_ins_rdy),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Memory contents as a pure function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0013;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_imem_gnt = 0; i_imem_rvalid = 0; i_imem_rdata = 0;
        i_ins_rdy = 0; i_redirect = 0; i_redirect_pc = 0;
        tick(); tick();
        n_cmp++; if (o_imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b exp=0", o_imem_req); end
        n_cmp++; if (o_ins !== 32'h13) begin n_bad++; $display("FAIL reset_ins got=%h exp=00000013", o_ins); end
        n_cmp++; if (o_ins_pc !== 32'h0) begin n_bad++; $display("FAIL reset_ins_pc got=%h exp=0", o_ins_pc); end
        n_cmp++; if (o_ins_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld got=%b exp=0", o_ins_vld); end
        n_cmp++; if (o_imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got=%h exp=0", o_imem_addr); end
        i_reset = 1'b1;
        tick(); // S_IDLE -> S_REQ
        n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin n_bad++; $display("FAIL first_req got=%b/%h exp=1/00000000", o_imem_req, o_imem_addr); end
    endtask

    task automatic test_basic();
        i_imem_gnt = 1; tick();
        n_cmp++; if (o_imem_req !== 1'b0) begin n_bad++; $display("FAIL wait_req got=%b exp=0", o_imem_req); end
        i_imem_gnt = 0; i_imem_rvalid = 1; i_imem_rdata = 32'h00500093; tick();
        i_imem_rvalid = 0;
        n_cmp++; if (o_ins_vld !== 1'b1 || o_ins !== 32'h00500093 || o_ins_pc !== 32'h0) begin n_bad++; $display("FAIL ins0 got=%b/%h/%h exp=1/00500093/00000000", o_ins_vld, o_ins, o_ins_pc); end
        i_ins_rdy = 1; tick();
        i_ins_rdy = 0;
        n_cmp++; if (o_ins_vld !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h4) begin n_bad++; $display("FAIL req1 got=%b/%b/%h exp=0/1/00000004", o_ins_vld, o_imem_req, o_imem_addr); end
        i_imem_gnt = 1; tick();
        i_imem_gnt = 0; i_imem_rvalid = 1; i_imem_rdata = 32'h00a00113; tick();
        i_imem_rvalid = 0;
        n_cmp++; if (o_ins_vld !== 1'b1 || o_ins !== 32'h00a00113 || o_ins_pc !== 32'h4) begin n_bad++; $display("FAIL ins1 got=%b/%h/%h exp=1/00a00113/00000004", o_ins_vld, o_ins, o_ins_pc); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (o_ins_vld !== 1'b1 || o_ins !== 32'h00a00113 || o_ins_pc !== 32'h4 || o_imem_req !== 1'b0) begin
                n_bad++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%h/%b exp=1/00a00113/00000004/0", i, o_ins_vld, o_ins, o_ins_pc, o_imem_req);
            end
        end
        i_ins_rdy = 1; tick();
        i_ins_rdy = 0;
        n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h8 || o_ins_vld !== 1'b0) begin n_bad++; $display("FAIL stall_release got=%b/%h/%b exp=1/00000008/0", o_imem_req, o_imem_addr, o_ins_vld); end
    endtask

    task automatic test_redirect_wait();
        i_imem_gnt = 1; tick();
        i_imem_gnt = 0; i_redirect = 1; i_redirect_pc = 32'h0000_0102; tick();
        i_redirect = 0;
        n_cmp++; if (o_imem_req !== 1'b0 || o_ins_vld !== 1'b0) begin n_bad++; $display("FAIL rw_wait got=%b/%b exp=0/0", o_imem_req, o_ins_vld); end
        tick();
        i_imem_rvalid = 1; i_imem_rdata = 32'hdeadbeef; tick();
        i_imem_rvalid = 0;
        n_cmp++; if (o_ins_vld !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h100) begin n_bad++; $display("FAIL rw_drop got=%b/%b/%h exp=0/1/00000100", o_ins_vld, o_imem_req, o_imem_addr); end
        n_cmp++; if (o_ins !== 32'h00a00113 || o_ins_pc !== 32'h4) begin n_bad++; $display("FAIL rw_ins_kept got=%h/%h exp=00a00113/00000004", o_ins, o_ins_pc); end
        i_imem_gnt = 1; tick();
        i_imem_gnt = 0; i_imem_rvalid = 1; i_imem_rdata = 32'h1234_5678; tick();
        i_imem_rvalid = 0;
        n_cmp++; if (o_ins_vld !== 1'b1 || o_ins_pc !== 32'h100 || o_ins !== 32'h1234_5678) begin n_bad++; $display("FAIL rw_deliver got=%b/%h/%h exp=1/00000100/12345678", o_ins_vld, o_ins_pc, o_ins); end
        i_ins_rdy = 1; tick();
        i_ins_rdy = 0;
    endtask

    task automatic test_redirect_gnt();
        i_imem_gnt = 1; i_redirect = 1; i_redirect_pc = 32'h0000_0200; tick();
        i_imem_gnt = 0; i_redirect = 0;
        n_cmp++; if (o_imem_req !== 1'b0) begin n_bad++; $display("FAIL rg_wait got=%b exp=0", o_imem_req); end
        i_imem_rvalid = 1; i_imem_rdata = 32'hbad0_0001; tick();
        i_imem_rvalid = 0;
        n_cmp++; if (o_ins_vld !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h200) begin n_bad++; $display("FAIL rg_drop got=%b/%b/%h exp=0/1/00000200", o_ins_vld, o_imem_req, o_imem_addr); end
        i_imem_gnt = 1; tick();
        i_imem_gnt = 0; i_imem_rvalid = 1; i_imem_rdata = 32'h1111_1111; tick();
        i_imem_rvalid = 0;
        n_cmp++; if (o_ins_vld !== 1'b1 || o_ins_pc !== 32'h200 || o_ins !== 32'h1111_1111) begin n_bad++; $display("FAIL rg_deliver got=%b/%h/%h exp=1/00000200/11111111", o_ins_vld, o_ins_pc, o_ins); end
        i_ins_rdy = 1; tick();
        i_ins_rdy = 0;
    endtask

    task automatic test_redirect_rvalid();
        i_imem_gnt = 1; tick();
        i_imem_gnt = 0; i_imem_rvalid = 1; i_imem_rdata = 32'hbad0_0002;
        i_redirect = 1; i_redirect_pc = 32'h0000_0301; tick();
        i_imem_rvalid = 0; i_redirect = 0;
        n_cmp++; if (o_ins_vld !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h300) begin n_bad++; $display("FAIL rr_drop got=%b/%b/%h exp=0/1/00000300", o_ins_vld, o_imem_req, o_imem_addr); end
        i_imem_gnt = 1; tick();
        i_imem_gnt = 0; i_imem_rvalid = 1; i_imem_rdata = 32'h2222_2222; tick();
        i_imem_rvalid = 0;
        n_cmp++; if (o_ins_vld !== 1'b1 || o_ins_pc !== 32'h300 || o_ins !== 32'h2222_2222) begin n_bad++; $display("FAIL rr_deliver got=%b/%h/%h exp=1/00000300/22222222", o_ins_vld, o_ins_pc, o_ins); end
        i_ins_rdy = 1; tick();
        i_ins_rdy = 0;
    endtask

    task automatic test_wrap();
        i_redirect = 1; i_redirect_pc = 32'hFFFF_FFFC; tick();
        i_redirect = 0;
        n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_req got=%b/%h exp=1/fffffffc", o_imem_req, o_imem_addr); end
        i_imem_gnt = 1; tick();
        i_imem_gnt = 0; i_imem_rvalid = 1; i_imem_rdata = 32'h3333_3333; tick();
        i_imem_rvalid = 0;
        n_cmp++; if (o_ins_vld !== 1'b1 || o_ins_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_deliver got=%b/%h exp=1/fffffffc", o_ins_vld, o_ins_pc); end
        i_ins_rdy = 1; tick();
        i_ins_rdy = 0;
        n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_next got=%b/%h exp=1/00000000", o_imem_req, o_imem_addr); end
    endtask

    task automatic test_reset_mid();
        i_redirect = 1; i_redirect_pc = 32'h0000_0400; tick();
        i_redirect = 0; i_imem_gnt = 1; tick();
        i_imem_gnt = 0; // now in S_WAIT at 0x400
        i_reset = 0; #1;
        n_cmp++; if (o_imem_req !== 1'b0 || o_imem_addr !== 32'h0 || o_ins !== 32'h13 || o_ins_pc !== 32'h0 || o_ins_vld !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid got=%b/%h/%h/%h/%b exp=0/00000000/00000013/00000000/0", o_imem_req, o_imem_addr, o_ins, o_ins_pc, o_ins_vld);
        end
        tick();
        i_reset = 1; i_imem_rvalid = 1; i_imem_rdata = 32'hbad0_0003; tick();
        i_imem_rvalid = 0;
        n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0 || o_ins_vld !== 1'b0 || o_ins !== 32'h13) begin n_bad++; $display("FAIL reset_stray got=%b/%h/%b/%h exp=1/00000000/0/00000013", o_imem_req, o_imem_addr, o_ins_vld, o_ins); end
        tick();
        n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0 || o_ins_vld !== 1'b0) begin n_bad++; $display("FAIL reset_stray2 got=%b/%h/%b exp=1/00000000/0", o_imem_req, o_imem_addr, o_ins_vld); end
    endtask

    // Transaction-level model: instructions are delivered in program order
    // starting at exp_pc; a redirect restarts program order at its target,
    // discarding anything still in flight. Memory answers 1..3 cycles after gnt.
    task automatic test_random();
        logic [31:0] exp_pc, prev_ins, prev_ins_pc, out_addr, tgt;
        logic        prev_vld, redir_prev, outstanding;
        int unsigned delay, idle, deliveries;
        i_reset = 0; i_imem_gnt = 0; i_imem_rvalid = 0; i_ins_rdy = 0; i_redirect = 0;
        tick();
        i_reset = 1;
        exp_pc = 32'h0; prev_vld = 0; prev_ins = 32'h13; prev_ins_pc = 32'h0;
        redir_prev = 0; tgt = 0; outstanding = 0; out_addr = 0; delay = 0;
        idle = 0; deliveries = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (redir_prev) begin
                exp_pc = tgt;
                idle = 0;
                n_cmp++; if (o_ins_vld !== 1'b0) begin n_bad++; $display("FAIL rnd_redirect_vld cyc=%0d got=%b exp=0", cyc, o_ins_vld); end
            end
            if (o_ins_vld && !prev_vld) begin
                n_cmp++;
                if (o_ins_pc !== exp_pc || o_ins !== mem_word(exp_pc)) begin
                    n_bad++; $display("FAIL rnd_deliver cyc=%0d got=%h/%h exp=%h/%h", cyc, o_ins_pc, o_ins, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                deliveries++;
                idle = 0;
            end else begin
                n_cmp++;
                if (o_ins !== prev_ins || o_ins_pc !== prev_ins_pc) begin
                    n_bad++; $display("FAIL rnd_ins_stable cyc=%0d got=%h/%h exp=%h/%h", cyc, o_ins, o_ins_pc, prev_ins, prev_ins_pc);
                end
                idle++;
            end
            if (o_imem_req && o_imem_addr[1:0] !== 2'b00) begin
                n_cmp++; n_bad++; $display("FAIL rnd_addr_align cyc=%0d got=%h", cyc, o_imem_addr);
            end
            if (idle > 60) begin
                n_cmp++; n_bad++; $display("FAIL rnd_liveness cyc=%0d no delivery for %0d cycles", cyc, idle);
                break;
            end
            prev_vld = o_ins_vld; prev_ins = o_ins; prev_ins_pc = o_ins_pc;

            i_imem_rvalid = 0;
            if (outstanding) begin
                if (delay == 0) begin
                    i_imem_rvalid = 1; i_imem_rdata = mem_word(out_addr); outstanding = 0;
                end else begin
                    delay--;
                end
            end
            i_imem_gnt = 0;
            if (o_imem_req && $urandom_range(0, 2) != 0) begin
                if (outstanding) begin
                    n_cmp++; n_bad++; $display("FAIL rnd_one_outstanding cyc=%0d req while fetch pending", cyc);
                end
                i_imem_gnt = 1; outstanding = 1; out_addr = o_imem_addr; delay = $urandom_range(0, 2);
            end
            i_ins_rdy = ($urandom_range(0, 1) == 1);
            i_redirect = ($urandom_range(0, 9) == 0);
            i_redirect_pc = $urandom();
            if ($urandom_range(0, 3) == 0) i_redirect_pc = 32'hFFFF_FFF0 | {28'h0, 4'($urandom_range(0, 15))};
            redir_prev = i_redirect;
            tgt = i_redirect_pc & 32'hFFFF_FFFC;
        end
        i_redirect = 0; i_imem_gnt = 0; i_imem_rvalid = 0; i_ins_rdy = 0;
        n_cmp++; if (deliveries < 100) begin n_bad++; $display("FAIL rnd_throughput got=%0d deliveries exp>=100", deliveries); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_gnt();
        test_redirect_rvalid();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch sequencer sitting between the instruction memory port and the decode stage (control unit, immediate generator, register file). It owns the PC, issues one fetch request at a time over a req/gnt/rvalid handshake, and holds the fetched word in an instruction register that stays stable until decode accepts it. It also handles PC redirects from branch/jump resolution, including killing a fetch already in flight.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  asynchronous, active-low reset
- o_imem_req  out  1  fetch request; high exactly while in S_REQ
- o_imem_addr  out  32  fetch address (= PC); bits [1:0] always 0
- i_imem_gnt  in  1  memory accepts request this cycle
- i_imem_rvalid  in  1  read data valid this cycle
- i_imem_rdata  in  32  fetched instruction word
- o_ins  out  32  instruction register to decode / immediate generation
- o_ins_pc  out  32  address of o_ins
- o_ins_vld  out  1  o_ins holds a live instruction
- i_ins_rdy  in  1  decode consumes o_ins this cycle (when o_ins_vld)
- i_redirect  in  1  replace PC with i_redirect_pc
- i_redirect_pc  in  32  redirect target; bits [1:0] are forced to 0 internally

## Operation
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD. Registers: pc, ins, ins_pc, ins_vld, drop.
- Reset (async, i_reset=0): state=S_IDLE, pc=RESET_PC, o_ins=32'h0000_0013 (NOP), o_ins_pc=RESET_PC, o_ins_vld=0, drop=0, o_imem_req=0.
- S_IDLE: unconditional move to S_REQ on the first edge after reset release.
- S_REQ: o_imem_req=1, o_imem_addr=pc. On i_imem_gnt go to S_WAIT; else stay.
- S_WAIT: on i_imem_rvalid: if drop, discard data, clear drop, go to S_REQ. Otherwise ins<=i_imem_rdata, ins_pc<=pc, ins_vld<=1, pc<=pc+4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0), go to S_HOLD.
- S_HOLD: o_ins_vld=1. o_ins and o_ins_pc are stable. On i_ins_rdy: ins_vld<=0, go to S_REQ.
- Redirect has priority over every other event in the same cycle:
  - pc<={i_redirect_pc[31:2],2'b00}.
  - ins_vld<=0. o_ins and o_ins_pc keep their old value.
  - S_IDLE/S_HOLD/S_REQ without gnt: go to S_REQ. The request address changes to the new PC on the next cycle.
  - S_REQ with gnt in the same cycle: drop<=1, go to S_WAIT.
  - S_WAIT without rvalid: drop<=1, stay in S_WAIT.
  - S_WAIT with rvalid in the same cycle: data discarded, drop<=0, go to S_REQ.
- At most one outstanding fetch at any time.
- i_imem_rvalid outside S_WAIT is a protocol error and is ignored. i_ins_rdy while o_ins_vld=0 is ignored.

## Timing
- o_imem_req, o_imem_addr and o_ins_vld are decoded from registered state only. No input-to-output combinational path.
- First request is high in cycle 1 after reset release (cycle 0 = first edge in S_IDLE).
- The memory may assert i_imem_rvalid at the earliest 1 cycle after gnt; any later cycle is also legal.
- With a zero-wait memory and i_ins_rdy tied high, one instruction is delivered every 3 cycles: REQ+gnt, WAIT+rvalid, HOLD+rdy.
- o_ins_vld rises on the edge after rvalid. It falls on the edge after a rdy or redirect cycle.
- Redirect to first request at the new PC is 1 cycle. When a fetch is being killed, add the remaining latency of the killed fetch.
- Reset asserted mid-fetch: all state is cleared immediately. A late rvalid after reset release lands in S_IDLE/S_REQ and is ignored.

## Test plan
- Reset, then zero-wait memory returning 32'h00500093 at 0x0 and 32'h00a00113 at 0x4, rdy=1 -> requests at addr 0x0 then 0x4. o_ins=32'h00500093 with o_ins_pc=0x0 while o_ins_vld=1, then 32'h00a00113 with o_ins_pc=0x4.
- Downstream stall: rdy=0 for 5 cycles after o_ins_vld -> o_ins and o_ins_pc are constant, o_imem_req=0 throughout. Release rdy -> next request at pc+4 one cycle later.
- Redirect in S_WAIT to 32'h0000_0102 with rvalid 2 cycles later carrying 32'hdeadbeef -> data discarded, o_ins_vld stays 0, next request at addr 32'h0000_0100.
- Redirect in the same cycle as gnt, and separately in the same cycle as rvalid -> exactly one stale response is dropped in each case. The next delivered o_ins_pc equals the redirect target.
- PC wrap: redirect to 32'hFFFF_FFFC, deliver one instruction -> next request address is 32'h0000_0000.
- Assert i_reset while in S_WAIT, release, then inject a stray rvalid -> outputs return to their reset values, the stray rvalid is ignored, and the first request is at RESET_PC.
